// File: rtl/phase_sequencer_if.sv
// Bundle of the phase sequencer's control and status signals.
//   run, mem_op, halt, mem_ack : driven by the instruction source / memory
//   phase[4:0]                 : one-hot F,R,X,M,W (0 when no instruction active)
//   mem_req, busy, halted, err : status decodes of the sequencer state
//   retired[31:0]              : number of completed W phases
// Modport slave is the sequencer's view; master is the environment's view.
interface phase_sequencer_if;
    logic        run;
    logic        mem_op;
    logic        halt;
    logic        mem_ack;
    logic [4:0]  phase;
    logic        mem_req;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    modport slave (
        input  run, mem_op, halt, mem_ack,
        output phase, mem_req, busy, halted, err, retired
    );

    modport master (
        output run, mem_op, halt, mem_ack,
        input  phase, mem_req, busy, halted, err, retired
    );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (Fetch, Read, eXecute, Memory, Writeback).
//   clk   : clock, all state changes on the rising edge
//   n_rst : synchronous active-low reset
//   bus   : phase_sequencer_if.slave carrying run/mem_op/halt/mem_ack in and
//           phase/mem_req/busy/halted/err/retired out
// Memory phases (F, and M when the instruction uses memory) wait for mem_ack;
// waiting WAIT_LIMIT cycles without an ack drops into a terminal ERROR state.
// All outputs are flops loaded from the next-state decode, so they carry no
// combinational path from the inputs.
module phase_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    phase_sequencer_if.slave   bus
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_F      = 3'd1,
        S_R      = 3'd2,
        S_X      = 3'd3,
        S_M      = 3'd4,
        S_W      = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          mop_r;
    logic          mop_next_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_next_s;
    logic          retire_s;

    logic [4:0]    phase_r;
    logic          mem_req_r;
    logic          busy_r;
    logic          halted_r;
    logic          err_r;
    logic [31:0]   retired_r;

    // One-hot phase decode of a state; non-instruction states decode to zero.
    function automatic logic [4:0] phase_of(input state_t s);
        logic [4:0] p;
        case (s)
            S_F:     p = 5'b00001;
            S_R:     p = 5'b00010;
            S_X:     p = 5'b00100;
            S_M:     p = 5'b01000;
            S_W:     p = 5'b10000;
            default: p = 5'b00000;
        endcase
        return p;
    endfunction

    // Next-state, memory-op latch and wait-counter logic.
    always_comb begin
        state_next_s    = state_r;
        mop_next_s      = mop_r;
        wait_cnt_next_s = wait_cnt_r;
        retire_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.run) begin
                    state_next_s    = S_F;
                    wait_cnt_next_s = {CW{1'b0}};
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_F: begin
                // Ack wins over a timeout that falls in the same cycle.
                if (bus.mem_ack) begin
                    state_next_s = S_R;
                end else if (wait_cnt_r == LAST_WAIT) begin
                    state_next_s = S_ERROR;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_R: begin
                state_next_s = S_X;
            end
            S_X: begin
                state_next_s    = S_M;
                mop_next_s      = bus.mem_op;
                wait_cnt_next_s = {CW{1'b0}};
            end
            S_M: begin
                if (!mop_r) begin
                    state_next_s = S_W;
                end else if (bus.mem_ack) begin
                    state_next_s = S_W;
                end else if (wait_cnt_r == LAST_WAIT) begin
                    state_next_s = S_ERROR;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_W: begin
                retire_s = 1'b1;
                // halt is only looked at here and outranks run.
                if (bus.halt) begin
                    state_next_s = S_HALTED;
                end else if (bus.run) begin
                    state_next_s    = S_F;
                    wait_cnt_next_s = {CW{1'b0}};
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_HALTED: begin
                state_next_s = S_HALTED;
            end
            S_ERROR: begin
                state_next_s = S_ERROR;
            end
            default: begin
                state_next_s = S_ERROR;
            end
        endcase
    end

    // State, latch, counter and output registers; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r    <= S_IDLE;
            mop_r      <= 1'b0;
            wait_cnt_r <= {CW{1'b0}};
            phase_r    <= 5'b00000;
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            err_r      <= 1'b0;
            retired_r  <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            mop_r      <= mop_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            phase_r    <= phase_of(state_next_s);
            mem_req_r  <= (state_next_s == S_F) || ((state_next_s == S_M) && mop_next_s);
            busy_r     <= |phase_of(state_next_s);
            halted_r   <= (state_next_s == S_HALTED);
            err_r      <= (state_next_s == S_ERROR);
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign bus.phase   = phase_r;
    assign bus.mem_req = mem_req_r;
    assign bus.busy    = busy_r;
    assign bus.halted  = halted_r;
    assign bus.err     = err_r;
    assign bus.retired = retired_r;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: max cycles a memory phase (F or memory-using M) may wait for mem_ack before error.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 run  input  1  enable; 1 = start/continue issuing instructions.
REQ-005 mem_op  input  1  current instruction accesses data memory in M; sampled during X.
REQ-006 halt  input  1  current instruction is a halt; sampled during W.
REQ-007 mem_ack  input  1  memory completion strobe for the current mem_req.
REQ-008 phase  output  5  one-hot phase: bit0 F, bit1 R, bit2 X, bit3 M, bit4 W; 0 when no instruction is active.
REQ-009 mem_req  output  1  memory request; high in F, and in M when the latched mem_op is 1.
REQ-010 busy  output  1  1 while any of phase[4:0] is 1.
REQ-011 halted  output  1  1 in HALTED state.
REQ-012 err  output  1  sticky memory-timeout error flag.
REQ-013 retired  output  32  count of completed W phases.

Function
REQ-014 States: IDLE, F, R, X, M, W, HALTED, ERROR; phase is the one-hot decode of F..W, 0 in all other states.
REQ-015 IDLE: run=1 -> F next cycle; run=0 -> stay IDLE.
REQ-016 F: mem_req=1; mem_ack=1 -> R next cycle; otherwise stay in F.
REQ-017 R -> X and X -> M unconditionally, one cycle each.
REQ-018 X: mem_op is latched into an internal flag at the X->M transition.
REQ-019 M with latched mem_op=0: mem_req=0, one cycle, -> W.
REQ-020 M with latched mem_op=1: mem_req=1 until mem_ack=1, then -> W next cycle.
REQ-021 W: retired increments by 1 (mod 2^32, wraps 0xFFFFFFFF -> 0); next state: halt=1 -> HALTED; else run=1 -> F; else IDLE.
REQ-022 halt has priority over run in W; halt ignored in every other state.
REQ-023 Minimum instruction latency: 5 cycles (F..W) when mem_ack is high in the first F cycle and mem_op=0.
REQ-024 run deasserted mid-instruction does not abort it; the sequence completes through W, then goes IDLE.
REQ-025 Wait counter: cleared on entry to F or M; increments each waiting cycle with mem_req=1 and mem_ack=0.
REQ-026 Waiting cycle in which counter = WAIT_LIMIT-1 and mem_ack=0 -> ERROR next cycle, err=1.
REQ-027 mem_ack=1 in the same cycle as the timeout condition: ack wins, normal transition, err unchanged.
REQ-028 mem_ack while mem_req=0 is ignored: no state change, no counter effect.
REQ-029 HALTED and ERROR are terminal; exit only via reset; mem_req=0, phase=0 in both.
REQ-030 Outputs phase, mem_req, busy, halted, err are registered-state decodes; no combinational path from inputs.

Reset
REQ-031 n_rst=0 at posedge clk: state IDLE, phase=0, mem_req=0, busy=0, halted=0, err=0, retired=0, wait counter=0, mem_op flag=0.
REQ-032 Reset has priority over every other condition, including mid-instruction, HALTED, and ERROR.
REQ-033 First cycle after reset release: IDLE; F is entered only after run=1 is sampled.

Verification
REQ-034 run=1, mem_ack=1 constant, mem_op=0, halt=0 -> phase 01,02,04,08,10 repeating; retired +1 every 5 cycles.
REQ-035 mem_ack held low 3 cycles in F, then high -> F lasts 4 cycles, mem_req=1 throughout, then R; err=0.
REQ-036 mem_op=1 in X, mem_ack after 2 M cycles -> M lasts 3 cycles with mem_req=1, then W.
REQ-037 WAIT_LIMIT=16, mem_ack never asserted in F -> ERROR after 16 F cycles, err=1, phase=0; mem_ack then ignored; n_rst=0 clears err.
REQ-038 halt=1 during W with run=1 -> HALTED, halted=1, phase=0, retired incremented once; stays until reset.
REQ-039 retired preloaded near wrap (0xFFFFFFFF via long run or forced state) -> next W gives 0; n_rst=0 in M -> IDLE, retired=0.
